instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_if.sv | 22 ++
 rtl/instruction_fetch_unit.sv | 94 +++++++++
 tb/tb_instruction_fetch_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// AXI4 read-only bus (AR and R channels) between the fetch unit and instruction memory.
interface instruction_fetch_unit_if;
  logic [31:0] s_axi_araddr;
  logic [1:0]  s_axi_arburst;
  logic [3:0]  s_axi_arid;
  logic [7:0]  s_axi_arlen;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  modport master (
    output s_axi_araddr, s_axi_arburst, s_axi_arid, s_axi_arlen, s_axi_arvalid, s_axi_rready,
    input  s_axi_arready, s_axi_rdata, s_axi_rvalid
  );

  modport slave (
    input  s_axi_araddr, s_axi_arburst, s_axi_arid, s_axi_arlen, s_axi_arvalid, s_axi_rready,
    output s_axi_arready, s_axi_rdata, s_axi_rvalid
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Single-beat AXI4 instruction fetcher holding one outstanding read at a time.
// Optional IFU_ALIGN_CHECK_EN: refuse fetch requests whose address is not word aligned.
module instruction_fetch_unit (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             fetch_enable,
  input  logic [31:0]                      fetch_addr,
  output logic [31:0]                      instruction,
  output logic                             instr_valid,
  instruction_fetch_unit_if.master         axi
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, VALID} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        req_ok;

`ifdef IFU_ALIGN_CHECK_EN
  assign req_ok = fetch_enable && (fetch_addr[1:0] == 2'b00);
`else
  assign req_ok = fetch_enable;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
    end
  end

  // A redirect to a new address goes straight back to ADDR; a refused one falls to IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    case (state_q)
      IDLE: begin
        if (req_ok) begin
          addr_d  = fetch_addr;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (axi.s_axi_arready) state_d = DATA;
      end
      DATA: begin
        if (axi.s_axi_rvalid) begin
          instr_d = axi.s_axi_rdata;
          if (!fetch_enable) begin
            state_d = IDLE;
          end else if (fetch_addr == addr_q) begin
            state_d = VALID;
          end else if (req_ok) begin
            addr_d  = fetch_addr;
            state_d = ADDR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      VALID: begin
        if (!fetch_enable) begin
          state_d = IDLE;
        end else if (fetch_addr != addr_q) begin
          if (req_ok) begin
            addr_d  = fetch_addr;
            state_d = ADDR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from registered state, so reset clears them asynchronously.
  assign axi.s_axi_arvalid = (state_q == ADDR);
  assign axi.s_axi_araddr  = {addr_q[31:2], 2'b00};
  assign axi.s_axi_arlen   = 8'h00;
  assign axi.s_axi_arburst = 2'b01;
  assign axi.s_axi_arid    = 4'h0;
  assign axi.s_axi_rready  = (state_q == DATA);
  assign instr_valid       = (state_q == VALID);
  assign instruction       = instr_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: randomized slave delays and addresses plus directed cases.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        resetn;
  logic        fetch_enable;
  logic [31:0] fetch_addr;
  logic [31:0] instruction;
  logic        instr_valid;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .fetch_enable (fetch_enable),
    .fetch_addr   (fetch_addr),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .axi          (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_ar[$];
  logic [31:0] exp_instr[$];
  int          ar_count = 0;

  int          ar_delay = 0;
  int          r_delay  = 0;
  logic        override_en = 1'b0;
  logic [31:0] override_data = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [31:0] addr);
    fetch_enable = en;
    fetch_addr   = addr;
  endtask

  task automatic waitValid(input int max, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!instr_valid && cycles < max);
  endtask

  task automatic waitRready(input int max);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.s_axi_rready && n < max);
    checkOutput("wait_rready", {31'b0, bus.s_axi_rready}, 32'h1);
  endtask

  // Slave: accepts AR after ar_delay cycles, returns one R beat after r_delay cycles.
  initial begin
    int phase;
    int cnt;
    logic [31:0] cap_addr;
    phase = 0;
    cnt = 0;
    cap_addr = 32'h0;
    bus.s_axi_arready = 1'b0;
    bus.s_axi_rvalid  = 1'b0;
    bus.s_axi_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        bus.s_axi_arready = 1'b0;
        bus.s_axi_rvalid  = 1'b0;
        phase = 0;
        cnt = 0;
      end else begin
        case (phase)
          0: begin
            bus.s_axi_rvalid = 1'b0;
            if (bus.s_axi_arvalid) begin
              if (cnt >= ar_delay) begin
                bus.s_axi_arready = 1'b1;
                cap_addr = bus.s_axi_araddr;
                cnt = 0;
                phase = 1;
              end else begin
                cnt++;
              end
            end
          end
          1: begin
            bus.s_axi_arready = 1'b0;
            if (cnt >= r_delay) begin
              bus.s_axi_rvalid = 1'b1;
              bus.s_axi_rdata  = override_en ? override_data : mem_word(cap_addr);
              cnt = 0;
              phase = 2;
            end else begin
              cnt++;
            end
          end
          default: begin
            bus.s_axi_rvalid = 1'b0;
            phase = 0;
          end
        endcase
      end
    end
  end

  // AR monitor: every address handshake must match the next expected word address.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (resetn && bus.s_axi_arvalid && bus.s_axi_arready) begin
        ar_count++;
        if (exp_ar.size() == 0) begin
          checkOutput("ar_unexpected", bus.s_axi_araddr, 32'hFFFFFFFF);
        end else begin
          checkOutput("ar_addr", bus.s_axi_araddr, exp_ar.pop_front());
        end
        checkOutput("ar_len", {24'b0, bus.s_axi_arlen}, 32'h0);
        checkOutput("ar_burst", {30'b0, bus.s_axi_arburst}, 32'h1);
        checkOutput("ar_id", {28'b0, bus.s_axi_arid}, 32'h0);
      end
    end
  end

  // Instruction monitor: a rising instr_valid consumes one expected word, which must then hold.
  initial begin
    logic prev_iv;
    logic [31:0] last_exp;
    prev_iv = 1'b0;
    last_exp = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      if (!resetn) begin
        prev_iv = 1'b0;
      end else begin
        if (instr_valid && !prev_iv) begin
          if (exp_instr.size() == 0) begin
            checkOutput("instr_unexpected", {31'b0, instr_valid}, 32'h0);
          end else begin
            last_exp = exp_instr.pop_front();
            checkOutput("instr_data", instruction, last_exp);
          end
        end else if (instr_valid && prev_iv) begin
          checkOutput("instr_hold", instruction, last_exp);
        end
        prev_iv = instr_valid;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int ar_before;
    logic seen;
    logic [31:0] a;
    logic [31:0] b;
    int mode;

    resetn = 1'b0;
    applyStimulus(1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("rst_instruction", instruction, 32'h0);
    checkOutput("rst_arvalid", {31'b0, bus.s_axi_arvalid}, 32'h0);
    checkOutput("rst_rready", {31'b0, bus.s_axi_rready}, 32'h0);
    checkOutput("rst_araddr", bus.s_axi_araddr, 32'h0);
    checkOutput("rst_arlen", {24'b0, bus.s_axi_arlen}, 32'h0);
    checkOutput("rst_arburst", {30'b0, bus.s_axi_arburst}, 32'h1);
    checkOutput("rst_arid", {28'b0, bus.s_axi_arid}, 32'h0);
    resetn = 1'b1;
    tick();

    // Slow AR slave returning DEADBEEF, held while enable stays high.
    ar_delay = 3;
    r_delay = 0;
    override_en = 1'b1;
    override_data = 32'hDEADBEEF;
    exp_ar.push_back(32'h4);
    exp_instr.push_back(32'hDEADBEEF);
    applyStimulus(1'b1, 32'h4);
    waitValid(20, cyc);
    checkOutput("basic_valid", {31'b0, instr_valid}, 32'h1);
    repeat (4) tick();
    checkOutput("basic_held_valid", {31'b0, instr_valid}, 32'h1);
    checkOutput("basic_held_instr", instruction, 32'hDEADBEEF);
    checkOutput("basic_no_new_ar", {31'b0, bus.s_axi_arvalid}, 32'h0);

    // Redirect from VALID to 0x8.
    ar_delay = 0;
    override_data = 32'h12345678;
    exp_ar.push_back(32'h8);
    exp_instr.push_back(32'h12345678);
    applyStimulus(1'b1, 32'h8);
    tick();
    checkOutput("redir_valid_drop", {31'b0, instr_valid}, 32'h0);
    checkOutput("redir_arvalid", {31'b0, bus.s_axi_arvalid}, 32'h1);
    checkOutput("redir_araddr", bus.s_axi_araddr, 32'h8);
    waitValid(20, cyc);
    checkOutput("redir_valid", {31'b0, instr_valid}, 32'h1);
    checkOutput("redir_instr", instruction, 32'h12345678);

    // Zero-wait latency from IDLE.
    override_en = 1'b0;
    applyStimulus(1'b0, 32'h8);
    tick();
    checkOutput("disable_drop", {31'b0, instr_valid}, 32'h0);
    ar_before = ar_count;
    exp_ar.push_back(32'h100);
    exp_instr.push_back(mem_word(32'h100));
    applyStimulus(1'b1, 32'h100);
    waitValid(20, cyc);
    checkOutput("latency_cycles", cyc, 32'd3);
    repeat (3) tick();
    checkOutput("latency_one_ar", ar_count - ar_before, 32'd1);

    // Enable dropped while AR waits: request completes but never becomes valid.
    applyStimulus(1'b0, 32'h100);
    tick();
    ar_delay = 4;
    ar_before = ar_count;
    exp_ar.push_back(32'h200);
    applyStimulus(1'b1, 32'h200);
    tick();
    applyStimulus(1'b0, 32'h300);
    seen = 1'b0;
    repeat (3) begin
      tick();
      checkOutput("abort_arvalid_held", {31'b0, bus.s_axi_arvalid}, 32'h1);
      checkOutput("abort_araddr_held", bus.s_axi_araddr, 32'h200);
    end
    repeat (12) begin
      tick();
      seen = seen | instr_valid;
    end
    checkOutput("abort_never_valid", {31'b0, seen}, 32'h0);
    checkOutput("abort_idle_arvalid", {31'b0, bus.s_axi_arvalid}, 32'h0);
    checkOutput("abort_idle_rready", {31'b0, bus.s_axi_rready}, 32'h0);
    checkOutput("abort_one_ar", ar_count - ar_before, 32'd1);

    // Asynchronous reset during DATA.
    ar_delay = 0;
    r_delay = 6;
    exp_ar.push_back(32'h40);
    applyStimulus(1'b1, 32'h40);
    waitRready(20);
    #1;
    resetn = 1'b0;
    #1;
    checkOutput("async_rst_rready", {31'b0, bus.s_axi_rready}, 32'h0);
    checkOutput("async_rst_arvalid", {31'b0, bus.s_axi_arvalid}, 32'h0);
    checkOutput("async_rst_valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("async_rst_instr", instruction, 32'h0);
    checkOutput("async_rst_araddr", bus.s_axi_araddr, 32'h0);
    exp_instr.delete();
    applyStimulus(1'b0, 32'h0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    checkOutput("post_rst_arvalid", {31'b0, bus.s_axi_arvalid}, 32'h0);
    checkOutput("post_rst_valid", {31'b0, instr_valid}, 32'h0);
    r_delay = 0;

    // Misaligned request.
`ifdef IFU_ALIGN_CHECK_EN
    ar_before = ar_count;
    applyStimulus(1'b1, 32'h6);
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen = seen | instr_valid | bus.s_axi_arvalid;
    end
    checkOutput("align_refused", {31'b0, seen}, 32'h0);
    checkOutput("align_no_ar", ar_count - ar_before, 32'd0);
    exp_ar.push_back(32'h10);
    exp_instr.push_back(mem_word(32'h10));
    applyStimulus(1'b1, 32'h10);
    waitValid(20, cyc);
    checkOutput("align_ok_valid", {31'b0, instr_valid}, 32'h1);
    applyStimulus(1'b1, 32'h12);
    tick();
    checkOutput("align_valid_drop", {31'b0, instr_valid}, 32'h0);
    tick();
    checkOutput("align_drop_no_ar", {31'b0, bus.s_axi_arvalid}, 32'h0);
`else
    exp_ar.push_back(32'h4);
    exp_instr.push_back(mem_word(32'h4));
    applyStimulus(1'b1, 32'h6);
    waitValid(20, cyc);
    checkOutput("unaligned_valid", {31'b0, instr_valid}, 32'h1);
`endif
    applyStimulus(1'b0, 32'h0);
    tick();

    // Randomized fetch sequences with random slave delays and redirects.
    for (int t = 0; t < 40; t++) begin
      a = $urandom_range(0, 32'hFFFF);
`ifdef IFU_ALIGN_CHECK_EN
      a = word_addr(a);
`endif
      if (fetch_enable && a == fetch_addr) a = a + 32'h4;
      ar_delay = $urandom_range(0, 3);
      r_delay = $urandom_range(0, 3);
      mode = $urandom_range(0, 2);
      exp_ar.push_back(word_addr(a));
      applyStimulus(1'b1, a);
      if (mode == 2) begin
        waitRready(20);
        b = a ^ 32'h40;
        exp_ar.push_back(word_addr(b));
        exp_instr.push_back(mem_word(word_addr(b)));
        applyStimulus(1'b1, b);
      end else begin
        exp_instr.push_back(mem_word(word_addr(a)));
      end
      waitValid(40, cyc);
      checkOutput("rand_valid", {31'b0, instr_valid}, 32'h1);
      repeat ($urandom_range(0, 3)) tick();
      checkOutput("rand_hold_valid", {31'b0, instr_valid}, 32'h1);
      if ($urandom_range(0, 1) == 1) begin
        applyStimulus(1'b0, fetch_addr);
        tick();
        checkOutput("rand_disable", {31'b0, instr_valid}, 32'h0);
      end
    end

    applyStimulus(1'b0, 32'h0);
    repeat (6) tick();
    checkOutput("ar_queue_empty", exp_ar.size(), 32'd0);
    checkOutput("instr_queue_empty", exp_instr.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
